// File: rtl/fetch_pkg.sv
// Shared types for the instruction-fetch sequencer: FSM states, fetch granule
// and the default prefetch-queue entry layout.
package fetch_pkg;

    localparam int unsigned INSTR_BYTES  = 4;
    localparam int unsigned DEF_ADDR_W   = 8;
    localparam int unsigned DEF_INSTR_W  = 32;

    typedef enum logic [1:0] {
        IDLE,
        FETCH,
        DRAIN,
        DONE
    } fetch_state_e;

    typedef struct packed {
        logic [DEF_ADDR_W-1:0]  pc;
        logic [DEF_INSTR_W-1:0] instr;
    } fetch_entry_t;

endpackage

// File: rtl/fetch_queue.sv
// Prefetch FIFO of {pc, instr} entries; flush empties it in one cycle and wins
// over a same-cycle push or pop. QDEPTH must be a power of two.
module fetch_queue
    import fetch_pkg::*;
#(
    parameter type         entry_t = fetch_entry_t,
    parameter int unsigned QDEPTH  = 2
) (
    input  logic   clk,
    input  logic   rst_n,
    input  logic   push,
    input  logic   pop,
    input  logic   flush,
    input  entry_t wdata,
    output logic   full,
    output logic   empty,
    output entry_t head
);

    localparam int unsigned PTR_W = $clog2(QDEPTH);
    localparam int unsigned CNT_W = PTR_W + 1;

    entry_t           mem_q [QDEPTH];
    entry_t           mem_d [QDEPTH];
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             do_push, do_pop;

    assign full  = (cnt_q == CNT_W'(QDEPTH));
    assign empty = (cnt_q == '0);
    assign head  = mem_q[rd_ptr_q];

    always_comb begin
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        cnt_d    = cnt_q;
        do_push  = push && !full;
        do_pop   = pop && !empty;
        if (flush) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            cnt_d    = '0;
        end else begin
            if (do_push) begin
                mem_d[wr_ptr_q] = wdata;
                wr_ptr_d        = wr_ptr_q + PTR_W'(1);
            end
            if (do_pop) begin
                rd_ptr_d = rd_ptr_q + PTR_W'(1);
            end
            case ({do_push, do_pop})
                2'b10:   cnt_d = cnt_q + CNT_W'(1);
                2'b01:   cnt_d = cnt_q - CNT_W'(1);
                default: cnt_d = cnt_q;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int unsigned i = 0; i < QDEPTH; i++) begin
                mem_q[i] <= '0;
            end
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            cnt_q    <= '0;
        end else begin
            mem_q    <= mem_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            cnt_q    <= cnt_d;
        end
    end

endmodule

// File: rtl/fetch_ctrl.sv
// Instruction-fetch sequencer: owns the PC, fills the prefetch queue and hands
// instructions to decode. Define FETCH_STALL_CNT_EN to build the stall counter.
module fetch_ctrl
    import fetch_pkg::*;
#(
    parameter int unsigned ADDR_W   = 8,
    parameter int unsigned INSTR_W  = 32,
    parameter int unsigned QDEPTH   = 2,
    parameter int unsigned PROG_END = 88
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               start,
    output logic [ADDR_W-1:0]  inst_address,
    input  logic [INSTR_W-1:0] instruction,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [INSTR_W-1:0] out_instr,
    output logic [ADDR_W-1:0]  out_pc,
    input  logic               redirect_valid,
    input  logic [ADDR_W-1:0]  redirect_pc,
    output logic               busy,
    output logic               done,
    output logic [15:0]        stall_cnt
);

    typedef struct packed {
        logic [ADDR_W-1:0]  pc;
        logic [INSTR_W-1:0] instr;
    } entry_t;

    // End tests are done one bit wider so PROG_END = 2^ADDR_W sees the carry.
    localparam logic [ADDR_W:0] PROG_END_X = (ADDR_W + 1)'(PROG_END);

    fetch_state_e      state_q, state_d;
    logic [ADDR_W-1:0] pc_q, pc_d;
    logic [ADDR_W:0]   pc_inc;
    logic [ADDR_W-1:0] redir_tgt;
    logic              push, pop, flush, q_full, q_empty;
    logic              stall, start_ok;
    entry_t            wdata, head;

    assign pc_inc    = {1'b0, pc_q} + (ADDR_W + 1)'(INSTR_BYTES);
    assign redir_tgt = {redirect_pc[ADDR_W-1:2], 2'b00};
    assign pop       = !q_empty && out_ready;
    assign wdata     = {pc_q, instruction};

    always_comb begin
        state_d  = state_q;
        pc_d     = pc_q;
        push     = 1'b0;
        flush    = 1'b0;
        stall    = 1'b0;
        start_ok = 1'b0;
        if (redirect_valid && (state_q == FETCH || state_q == DRAIN)) begin
            flush   = 1'b1;
            pc_d    = redir_tgt;
            state_d = ({1'b0, redir_tgt} < PROG_END_X) ? FETCH : DRAIN;
        end else begin
            unique case (state_q)
                IDLE, DONE: begin
                    if (start) begin
                        state_d  = FETCH;
                        pc_d     = '0;
                        start_ok = 1'b1;
                    end
                end
                FETCH: begin
                    if (!q_full) begin
                        push = 1'b1;
                        pc_d = pc_inc[ADDR_W-1:0];
                        if (pc_inc >= PROG_END_X) state_d = DRAIN;
                    end else begin
                        stall = 1'b1;
                    end
                end
                DRAIN: begin
                    if (q_empty) state_d = DONE;
                end
                default: state_d = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            pc_q    <= '0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
        end
    end

    fetch_queue #(
        .entry_t (entry_t),
        .QDEPTH  (QDEPTH)
    ) u_queue (
        .clk   (clk),
        .rst_n (rst_n),
        .push  (push),
        .pop   (pop),
        .flush (flush),
        .wdata (wdata),
        .full  (q_full),
        .empty (q_empty),
        .head  (head)
    );

    assign inst_address = pc_q;
    assign out_valid    = !q_empty;
    assign out_instr    = head.instr;
    assign out_pc       = head.pc;
    assign busy         = (state_q == FETCH) || (state_q == DRAIN);
    assign done         = (state_q == DONE);

`ifdef FETCH_STALL_CNT_EN
    logic [15:0] stall_cnt_q, stall_cnt_d;

    always_comb begin
        stall_cnt_d = stall_cnt_q;
        if (start_ok) begin
            stall_cnt_d = '0;
        end else if (stall && stall_cnt_q != '1) begin
            stall_cnt_d = stall_cnt_q + 16'd1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) stall_cnt_q <= '0;
        else        stall_cnt_q <= stall_cnt_d;
    end

    assign stall_cnt = stall_cnt_q;

    logic unused_bits;
    assign unused_bits = ^redirect_pc[1:0];
`else
    assign stall_cnt = '0;

    logic unused_bits;
    assign unused_bits = stall ^ start_ok ^ (^redirect_pc[1:0]);
`endif

endmodule

// File: tb/tb_fetch_ctrl.sv
// Directed bench for fetch_ctrl: full-program delivery, stall, redirect,
// out-of-range redirect, restart from DONE and asynchronous reset.
module tb_fetch_ctrl;

`ifdef FETCH_STALL_CNT_EN
    localparam logic [15:0] STALL_ON = 16'd1;
`else
    localparam logic [15:0] STALL_ON = 16'd0;
`endif

    logic        clk = 1'b0;
    logic        rst_n;
    logic        start;
    logic [7:0]  inst_address;
    logic [31:0] instruction;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_instr;
    logic [7:0]  out_pc;
    logic        redirect_valid;
    logic [7:0]  redirect_pc;
    logic        busy;
    logic        done;
    logic [15:0] stall_cnt;

    int unsigned n_cmp = 0;
    int unsigned n_bad = 0;

    always #5 clk = ~clk;

    fetch_ctrl #(
        .ADDR_W   (8),
        .INSTR_W  (32),
        .QDEPTH   (2),
        .PROG_END (88)
    ) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .start          (start),
        .inst_address   (inst_address),
        .instruction    (instruction),
        .out_valid      (out_valid),
        .out_ready      (out_ready),
        .out_instr      (out_instr),
        .out_pc         (out_pc),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .busy           (busy),
        .done           (done),
        .stall_cnt      (stall_cnt)
    );

    // Program image: known words at 0x00, 0x04, 0x34, 0x54; filler elsewhere.
    function automatic logic [31:0] prog_word(input logic [31:0] k);
        case (k)
            32'd0:   return 32'h0500_0093;
            32'd1:   return 32'h0A00_0113;
            32'd13:  return 32'h0020_1B33;
            32'd21:  return 32'h0500_0B13;
            default: return 32'h0000_0013 | (k << 20);
        endcase
    endfunction

    always_comb instruction = prog_word({26'd0, inst_address[7:2]});

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic run_program(input string tag);
        int unsigned got = 0;
        int          first_valid = -1;
        int          done_cyc = -1;
        start = 1'b1;
        out_ready = 1'b1;
        redirect_valid = 1'b0;
        tick();
        start = 1'b0;
        check({tag, " stall_cnt after start"}, 32'(stall_cnt), 32'd0);
        for (int cyc = 1; cyc < 80; cyc++) begin
            if (cyc == 1) begin
                check({tag, " busy c1"}, 32'(busy), 32'd1);
                check({tag, " valid c1"}, 32'(out_valid), 32'd0);
            end
            if (out_valid) begin
                if (first_valid < 0) first_valid = cyc;
                check($sformatf("%s pc #%0d", tag, got), 32'(out_pc), got * 4);
                check($sformatf("%s instr #%0d", tag, got), out_instr, prog_word(got));
                got++;
            end
            if (done) begin
                done_cyc = cyc;
                break;
            end
            tick();
        end
        check({tag, " first valid cycle"}, 32'(first_valid), 32'd2);
        check({tag, " delivered count"}, got, 32'd22);
        check({tag, " done cycle"}, 32'(done_cyc), 32'd25);
        check({tag, " done"}, 32'(done), 32'd1);
        check({tag, " busy at end"}, 32'(busy), 32'd0);
        check({tag, " valid at end"}, 32'(out_valid), 32'd0);
    endtask

    typedef struct {
        logic        start;
        logic        ready;
        logic        rv;
        logic [7:0]  rpc;
        logic        ev;
        logic [7:0]  epc;
        logic [7:0]  eaddr;
        logic        ebusy;
        logic        edone;
        logic [15:0] estall;
    } vec_t;

    vec_t vecs[14];

    initial begin
        rst_n = 1'b0;
        start = 1'b0;
        out_ready = 1'b0;
        redirect_valid = 1'b0;
        redirect_pc = '0;
        #1;
        check("reset valid", 32'(out_valid), 32'd0);
        check("reset addr", 32'(inst_address), 32'd0);
        check("reset out_pc", 32'(out_pc), 32'd0);
        check("reset out_instr", out_instr, 32'd0);
        check("reset busy", 32'(busy), 32'd0);
        check("reset done", 32'(done), 32'd0);
        check("reset stall_cnt", 32'(stall_cnt), 32'd0);
        repeat (2) @(posedge clk);
        #3 rst_n = 1'b1;
        tick();
        check("idle busy", 32'(busy), 32'd0);

        run_program("boot");

        // Stall with ready low, resume, redirect to 0x37, then past PROG_END.
        vecs[0]  = '{1, 0, 0, 8'h00, 0, 8'h00, 8'h58, 0, 1, 16'd0};
        vecs[1]  = '{0, 0, 0, 8'h00, 0, 8'h00, 8'h00, 1, 0, 16'd0};
        vecs[2]  = '{0, 0, 0, 8'h00, 1, 8'h00, 8'h04, 1, 0, 16'd0};
        vecs[3]  = '{0, 0, 0, 8'h00, 1, 8'h00, 8'h08, 1, 0, 16'd0};
        vecs[4]  = '{0, 0, 0, 8'h00, 1, 8'h00, 8'h08, 1, 0, 16'd1};
        vecs[5]  = '{0, 1, 0, 8'h00, 1, 8'h00, 8'h08, 1, 0, 16'd2};
        vecs[6]  = '{0, 1, 0, 8'h00, 1, 8'h04, 8'h08, 1, 0, 16'd3};
        vecs[7]  = '{0, 1, 0, 8'h00, 1, 8'h08, 8'h0C, 1, 0, 16'd3};
        vecs[8]  = '{0, 1, 1, 8'h37, 1, 8'h0C, 8'h10, 1, 0, 16'd3};
        vecs[9]  = '{0, 1, 0, 8'h00, 0, 8'h00, 8'h34, 1, 0, 16'd3};
        vecs[10] = '{0, 1, 0, 8'h00, 1, 8'h34, 8'h38, 1, 0, 16'd3};
        vecs[11] = '{0, 1, 1, 8'h60, 1, 8'h38, 8'h3C, 1, 0, 16'd3};
        vecs[12] = '{0, 1, 0, 8'h00, 0, 8'h00, 8'h60, 1, 0, 16'd3};
        vecs[13] = '{0, 1, 0, 8'h00, 0, 8'h00, 8'h60, 0, 1, 16'd3};

        for (int i = 0; i < 14; i++) begin
            start = vecs[i].start;
            out_ready = vecs[i].ready;
            redirect_valid = vecs[i].rv;
            redirect_pc = vecs[i].rpc;
            check($sformatf("v%0d valid", i), 32'(out_valid), 32'(vecs[i].ev));
            check($sformatf("v%0d addr", i), 32'(inst_address), 32'(vecs[i].eaddr));
            check($sformatf("v%0d busy", i), 32'(busy), 32'(vecs[i].ebusy));
            check($sformatf("v%0d done", i), 32'(done), 32'(vecs[i].edone));
            check($sformatf("v%0d stall_cnt", i), 32'(stall_cnt), 32'(vecs[i].estall * STALL_ON));
            if (vecs[i].ev) begin
                check($sformatf("v%0d out_pc", i), 32'(out_pc), 32'(vecs[i].epc));
                check($sformatf("v%0d out_instr", i), out_instr, prog_word({26'd0, vecs[i].epc[7:2]}));
            end
            if (i == 10) check("redirect head ADD", out_instr, 32'h0020_1B33);
            tick();
        end
        start = 1'b0;
        redirect_valid = 1'b0;

        run_program("restart");

        // Asynchronous reset with two entries queued.
        start = 1'b1;
        out_ready = 1'b0;
        tick();
        start = 1'b0;
        tick();
        tick();
        check("pre-reset valid", 32'(out_valid), 32'd1);
        check("pre-reset addr", 32'(inst_address), 32'd8);
        #2 rst_n = 1'b0;
        #1;
        check("async rst valid", 32'(out_valid), 32'd0);
        check("async rst busy", 32'(busy), 32'd0);
        check("async rst addr", 32'(inst_address), 32'd0);
        check("async rst stall_cnt", 32'(stall_cnt), 32'd0);
        tick();
        #2 rst_n = 1'b1;
        out_ready = 1'b1;
        repeat (3) tick();
        check("post-rst idle busy", 32'(busy), 32'd0);
        check("post-rst idle done", 32'(done), 32'd0);
        check("post-rst idle addr", 32'(inst_address), 32'd0);
        check("post-rst idle valid", 32'(out_valid), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
